// File: rtl/mutex_req_pkg.sv
// Shared state codes, default widths and helpers for the
// requester-side mutex driver.
package mutex_req_pkg;

    localparam int DEF_NUM_REQ     = 5;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_W      = 8;
    localparam int DEF_TMO_W       = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    function automatic int unsigned popcount(
        input logic [31:0] v
    );
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/mutex_req_chan.sv
// One requester channel: 4-phase handshake FSM with
// hold and timeout counters.
module mutex_req_chan
    import mutex_req_pkg::*;
#(
    parameter int HOLD_W = DEF_HOLD_W,
    parameter int TMO_W  = DEF_TMO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    input  logic [HOLD_W-1:0] job_hold,
    input  logic              gnt_s,
    output logic              job_ready,
    output logic              req,
    output logic              done,
    output logic              proto_evt,
    output logic              err_tmo,
    output logic              busy
);

    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              waiting;
    logic              tmo_sat;

    assign waiting = (state_q == ST_REQ)
                  || (state_q == ST_REL);
    assign tmo_sat = &tmo_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (job_valid) state_d = ST_REQ;
            ST_REQ:  if (gnt_s) state_d = ST_HOLD;
            // a lost grant ends the hold early
            ST_HOLD: if (!gnt_s || cnt_q <= HOLD_ONE)
                         state_d = ST_REL;
            ST_REL:  if (!gnt_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_tmo <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && job_valid) begin
                hold_q <= (job_hold == '0) ? HOLD_ONE
                                           : job_hold;
            end
            if (state_q == ST_REQ && gnt_s) begin
                cnt_q <= hold_q;
            end else if (state_q == ST_HOLD) begin
                cnt_q <= cnt_q - HOLD_ONE;
            end
            if (state_d != state_q) begin
                tmo_q <= '0;
            end else if (waiting && !tmo_sat) begin
                tmo_q <= tmo_q + TMO_ONE;
            end
            if (waiting && tmo_sat) begin
                err_tmo <= 1'b1;
            end
        end
    end

    assign job_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign req       = (state_q == ST_REQ)
                    || (state_q == ST_HOLD);
    assign done      = (state_q == ST_REL) && !gnt_s;
    assign proto_evt = ((state_q == ST_IDLE) && gnt_s)
                    || ((state_q == ST_HOLD) && !gnt_s);

endmodule

// File: rtl/mutex_req_driver.sv
// Requester-side controller for an N-way asynchronous
// mutex: grant synchronisers, channels and monitor.
module mutex_req_driver
    import mutex_req_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_W      = DEF_HOLD_W,
    parameter int TMO_W       = DEF_TMO_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        job_valid,
    input  logic [NUM_REQ*HOLD_W-1:0] job_hold,
    output logic [NUM_REQ-1:0]        job_ready,
    output logic [NUM_REQ-1:0]        req_o,
    input  logic [NUM_REQ-1:0]        grant_i,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err_multi,
    output logic                      err_proto,
    output logic [NUM_REQ-1:0]        err_tmo,
    output logic                      busy
);

    logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_REQ-1:0] gnt_s;
    logic [NUM_REQ-1:0] proto_evt;
    logic [NUM_REQ-1:0] busy_ch;

    // grant_i is asynchronous; only gnt_s reaches the FSMs
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= grant_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign gnt_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_multi <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            if (popcount(32'(gnt_s)) > 1) begin
                err_multi <= 1'b1;
            end
            if (|proto_evt) begin
                err_proto <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
        mutex_req_chan #(
            .HOLD_W (HOLD_W),
            .TMO_W  (TMO_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .job_valid (job_valid[i]),
            .job_hold  (job_hold[i*HOLD_W +: HOLD_W]),
            .gnt_s     (gnt_s[i]),
            .job_ready (job_ready[i]),
            .req       (req_o[i]),
            .done      (done[i]),
            .proto_evt (proto_evt[i]),
            .err_tmo   (err_tmo[i]),
            .busy      (busy_ch[i])
        );
    end

    assign busy = |busy_ch;

endmodule

// File: tb/tb_mutex_req_driver.sv
// Bench: behavioural 5-way mutex, randomized jobs and a
// per-channel scoreboard checked on every done pulse.
module tb_mutex_req_driver;

    localparam int N    = 5;
    localparam int SYNC = 2;
    localparam int HW   = 8;
    localparam int GDLY = 10;

    logic            clk;
    logic            rst;
    logic [N-1:0]    job_valid;
    logic [N*HW-1:0] job_hold;
    logic [N-1:0]    job_ready;
    logic [N-1:0]    req_o;
    logic [N-1:0]    grant_i;
    logic [N-1:0]    done;
    logic            err_multi;
    logic            err_proto;
    logic [N-1:0]    err_tmo;
    logic            busy;

    logic [N-1:0] arb_gnt;
    logic [N-1:0] block_mask;
    logic         force_en;
    logic [N-1:0] force_val;
    logic [N-1:0] gcap;
    logic [N-1:0] prev_req;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int holder = -1;
    int exp_q [N][$];
    int hcnt [N];
    int fall_cyc [N];

    assign grant_i = force_en ? force_val : arb_gnt;

    mutex_req_driver #(
        .NUM_REQ     (N),
        .SYNC_STAGES (SYNC),
        .HOLD_W      (HW),
        .TMO_W       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .job_valid (job_valid),
        .job_hold  (job_hold),
        .job_ready (job_ready),
        .req_o     (req_o),
        .grant_i   (grant_i),
        .done      (done),
        .err_multi (err_multi),
        .err_proto (err_proto),
        .err_tmo   (err_tmo),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    // Mutex model: one holder at a time, lowest request
    // first, grant follows request after GDLY.
    initial begin
        arb_gnt = '0;
        #1;
        forever begin
            #2;
            if (holder >= 0) begin
                if (!req_o[holder]) begin
                    #GDLY;
                    arb_gnt[holder] = 1'b0;
                    holder = -1;
                end
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (holder < 0 && req_o[i]
                        && !block_mask[i]) holder = i;
                end
                if (holder >= 0) begin
                    #GDLY;
                    arb_gnt[holder] = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) gcap <= grant_i;

    // Monitor: hold length and release latency per job
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (rst) hcnt[i] = 0;
            else if (gcap[i] && req_o[i]) hcnt[i]++;
            if (prev_req[i] && !req_o[i]) fall_cyc[i] = cyc;
            if (done[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("unexpected_done%0d", i),
                        1, 0);
                end else begin
                    chk($sformatf("hold_len%0d", i),
                        hcnt[i] - SYNC,
                        exp_q[i].pop_front());
                    chk($sformatf("done_lat%0d", i),
                        cyc - fall_cyc[i], SYNC);
                end
                hcnt[i] = 0;
            end
        end
        prev_req = req_o;
    end

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < N; i++) n += exp_q[i].size();
        return n;
    endfunction

    function automatic int hold_of(input int ch);
        int h = int'(job_hold[ch*HW +: HW]);
        return (h == 0) ? 1 : h;
    endfunction

    task automatic issue(input logic [N-1:0] m);
        int n = 0;
        @(negedge clk);
        while (((job_ready & m) != m) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", (n < 2000), 1);
        job_valid = m;
        for (int i = 0; i < N; i++) begin
            if (m[i]) exp_q[i].push_back(hold_of(i));
        end
        @(posedge clk);
        #1;
        job_valid = '0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) chk($sformatf("req_after_accept%0d", i),
                          req_o[i], 1);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || pending() != 0) && n < 3000);
        chk(name, (n < 3000), 1);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] m;
        int n;
        rst        = 1'b1;
        job_valid  = '0;
        job_hold   = '0;
        block_mask = '0;
        force_en   = 1'b0;
        force_val  = '0;
        prev_req   = '0;
        for (int i = 0; i < N; i++) begin
            hcnt[i]     = 0;
            fall_cyc[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_req", req_o, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", job_ready, 5'h1f);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_multi, err_proto, err_tmo}, 0);

        // single job, then a back-to-back request on ch0
        job_hold[0 +: HW] = 8'd3;
        issue(5'b00001);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done[0] && n < 200);
        chk("b2b_done_seen", (n < 200), 1);
        job_valid[0]      = 1'b1;
        job_hold[0 +: HW] = 8'd5;
        exp_q[0].push_back(5);
        @(posedge clk);
        #1;
        chk("b2b_not_accepted", {job_ready[0], req_o[0]},
            2'b10);
        @(posedge clk);
        #1;
        job_valid[0] = 1'b0;
        chk("b2b_accepted", req_o[0], 1);
        wait_idle("t1_idle");

        // all five at once, hold 4
        for (int i = 0; i < N; i++) job_hold[i*HW +: HW] = 8'd4;
        issue(5'h1f);
        wait_idle("t2_idle");
        chk("t2_multi", err_multi, 0);

        // randomized traffic
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            m = N'($urandom_range(1, 31)) & job_ready;
            for (int i = 0; i < N; i++) begin
                job_hold[i*HW +: HW] = 8'($urandom_range(0, 7));
            end
            if (m != 0) issue(m);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle("rand_idle");
        chk("rand_errs", {err_multi, err_proto, err_tmo}, 0);

        // ch2 never granted: timeout, request kept
        block_mask = 5'b00100;
        job_hold[2*HW +: HW] = 8'd2;
        issue(5'b00100);
        repeat (249) @(posedge clk);
        #1;
        chk("tmo_early", err_tmo, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("tmo_set", err_tmo, 5'b00100);
        chk("tmo_req_kept", req_o[2], 1);
        block_mask = '0;
        wait_idle("t4_idle");
        chk("tmo_sticky", err_tmo, 5'b00100);

        // reset while ch1 is holding
        job_hold[1*HW +: HW] = 8'd20;
        issue(5'b00010);
        n = 0;
        while (!gcap[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (SYNC + 3) @(negedge clk);
        chk("t5_in_hold", req_o[1] && gcap[1], 1);
        rst = 1'b1;
        exp_q[1].delete();
        @(posedge clk);
        #1;
        chk("t5_req_dropped", req_o, 0);
        chk("t5_no_done", done, 0);
        repeat (SYNC + 2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_errs_cleared",
            {err_multi, err_proto, err_tmo}, 0);
        repeat (6) @(negedge clk);
        chk("t5_idle", {busy, job_ready}, 6'h1f);

        // zero hold treated as one cycle
        job_hold[4*HW +: HW] = 8'd0;
        issue(5'b10000);
        wait_idle("t6_idle");
        chk("t6_proto_clean", err_proto, 0);
        @(negedge clk);
        force_val = 5'b01000;
        force_en  = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        #1;
        chk("t6_proto", err_proto, 1);
        chk("t6_no_multi", err_multi, 0);
        @(negedge clk);
        force_en = 1'b0;
        repeat (SYNC + 2) @(negedge clk);

        // two grants at once
        force_val = 5'b00011;
        force_en  = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1;
        chk("t3_not_yet", err_multi, 0);
        @(posedge clk);
        #1;
        chk("t3_multi", err_multi, 1);
        @(negedge clk);
        force_en = 1'b0;
        repeat (8) @(negedge clk);
        chk("t3_sticky", err_multi, 1);
        do_reset(SYNC + 2);
        chk("t3_cleared", {err_multi, err_proto}, 0);
        chk("end_pending", pending(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
